// File: rtl/derived_clock_pkg.sv
// Shared definitions for the derived clock controller.
//   state_t     : controller state encoding
//   SYNC_STAGES : number of flops in the clk_in synchroniser
package derived_clock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_both.sv
// Synchroniser plus both-edge detector for an asynchronous input.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   a_async    in   asynchronous input, not yet synchronised
//   edge_pulse out  one-clk pulse for every rising or falling transition of a_async
// The transition is consumed by logic on the third posedge after it occurs:
// two synchroniser flops, then the compare against the previous sample.
module sync_edge_both
  import derived_clock_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_async,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_async};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/derived_clock_ctrl.sv
// Derived clock sequencing controller.
// Counts both edges of clk_in (in the clk domain) and toggles output_clk every
// n_act counted edges. New ratios arrive over a valid/ready handshake and are
// applied only at a toggle while running, so output_clk never glitches. A
// watchdog moves to LOST when clk_in stops.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   clk_in     in   asynchronous source clock
//   enable     in   run request (level)
//   cfg_n      in   requested ratio, edges per toggle; 0 disables the output
//   cfg_valid  in   cfg_n valid
//   cfg_ready  out  controller can accept cfg_n
//   output_clk out  derived clock
//   running    out  state is RUN
//   lost       out  state is LOST
module derived_clock_ctrl
  import derived_clock_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_in,
  input  logic         enable,
  input  logic [W-1:0] cfg_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic         output_clk,
  output logic         running,
  output logic         lost
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  state_t          state;
  logic [W-1:0]    n_act;
  logic [W-1:0]    n_pend;
  logic            pend;
  logic [W-1:0]    count;
  logic [WD_W-1:0] wdog;

  logic            edge_seen;
  logic            xfer;
  logic [W-1:0]    count_inc;
  logic            run_hit;
  logic            first_hit;

  sync_edge_both u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_async    (clk_in),
    .edge_pulse (edge_seen)
  );

  assign xfer      = cfg_valid & cfg_ready;
  assign count_inc = count + W'(1);
  // >= rather than == keeps the counter bounded even if a smaller ratio was
  // applied while a partial count from the old ratio was still held.
  assign run_hit   = (count_inc >= n_act);
  // Edge leaving ARM/LOST is the first of a fresh period.
  assign first_hit = (n_act == W'(1));

  assign running = (state == RUN);
  assign lost    = (state == LOST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_act      <= '0;
      n_pend     <= '0;
      pend       <= 1'b0;
      count      <= '0;
      wdog       <= '0;
      output_clk <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      // cfg_ready is low whenever pend is set, so a transfer and an apply
      // never happen in the same cycle.
      if (xfer) begin
        n_pend    <= cfg_n;
        pend      <= 1'b1;
        cfg_ready <= 1'b0;
      end

      if (!enable) begin
        state      <= IDLE;
        output_clk <= 1'b0;
        count      <= '0;
        wdog       <= '0;
        // A config pending from RUN is applied once the controller sits in IDLE.
        if (pend && state != RUN) begin
          n_act     <= n_pend;
          pend      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            output_clk <= 1'b0;
            count      <= '0;
            wdog       <= '0;
            if (pend) begin
              n_act     <= n_pend;
              pend      <= 1'b0;
              cfg_ready <= 1'b1;
            end else if (n_act != '0) begin
              state <= ARM;
            end
          end

          ARM: begin
            count <= '0;
            wdog  <= '0;
            if (pend) begin
              n_act     <= n_pend;
              pend      <= 1'b0;
              cfg_ready <= 1'b1;
            end
            if (pend && n_pend == '0) begin
              state      <= IDLE;
              output_clk <= 1'b0;
            end else if (edge_seen) begin
              state <= RUN;
              if (first_hit) output_clk <= ~output_clk;
              else           count      <= W'(1);
            end
          end

          RUN: begin
            if (edge_seen) begin
              wdog <= '0;
              if (run_hit) begin
                count <= '0;
                // The toggle closes the old period; a pending ratio starts
                // with the next one.
                if (pend) begin
                  n_act     <= n_pend;
                  pend      <= 1'b0;
                  cfg_ready <= 1'b1;
                end
                if (pend && n_pend == '0) begin
                  state      <= IDLE;
                  output_clk <= 1'b0;
                end else begin
                  output_clk <= ~output_clk;
                end
              end else begin
                count <= count_inc;
              end
            end else if (wdog == WD_MAX) begin
              state <= LOST;
            end else begin
              wdog <= wdog + WD_W'(1);
            end
          end

          LOST: begin
            // output_clk and count hold; wdog stays saturated.
            if (pend) begin
              n_act     <= n_pend;
              pend      <= 1'b0;
              cfg_ready <= 1'b1;
            end
            if (pend && n_pend == '0) begin
              state      <= IDLE;
              output_clk <= 1'b0;
              count      <= '0;
            end else if (edge_seen) begin
              state <= RUN;
              wdog  <= '0;
              if (first_hit) begin
                output_clk <= ~output_clk;
                count      <= '0;
              end else begin
                count <= W'(1);
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
